ceespu_intc: RTL and testbench

Interrupt controller for the ceespu core. It collects eight external interrupt sources and prioritises them. It drives the core's `I_int_req`/`I_int_vector` inputs and consumes `O_int_ack`, holding at most one interrupt in service at a time. Software configures it through a small register port decoded off the data-memory bus.

---
 rtl/ceespu_intc.sv | 196 +++++++++++++++++++
 tb/tb_ceespu_intc.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ceespu_intc.sv
// ceespu_intc: eight-source interrupt controller for the ceespu core.
// Raw sources are synchronized, latched as edge- or level-triggered pending
// bits, masked by ENABLE and prioritised (bit 0 highest). One request at a
// time is offered to the core, which acknowledges it and later issues an EOI
// through the register port.
// SYNC_STAGES must be 2 or 3; the chain is written generically but only
// those depths are intended.

module ceespu_intc #(
  parameter logic [7:0] EDGE_MASK   = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic [7:0] I_irq,
  output logic       O_int_req,
  output logic [2:0] O_int_vector,
  input  logic       I_int_ack,
  input  logic       I_cfgE,
  input  logic       I_cfgWe,
  input  logic [1:0] I_cfgAddr,
  input  logic [7:0] I_cfgWData,
  output logic [7:0] O_cfgRData
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_PEND   = 2'd0;
  localparam logic [1:0] ADDR_ENABLE = 2'd1;
  localparam logic [1:0] ADDR_INSERV = 2'd2;

  // Synchronizer chain; the last stage is the usable sampled source vector.
  logic [SYNC_STAGES-1:0][7:0] sync_reg;
  logic [7:0]                  s;

  logic [7:0] pend;
  logic [7:0] enable_reg;
  logic [7:0] elig;
  logic [7:0] inserv_reg;
  logic [2:0] vec_reg;
  logic [2:0] winner;
  state_t     state_reg;
  logic       int_req_reg;
  logic [2:0] int_vector_reg;
  logic [7:0] rdata_reg;
  logic [7:0] rdata_next;

  logic cfg_wr;
  logic w1c;
  logic enable_wr;
  logic eoi;
  logic ack_fire;

  assign s = sync_reg[SYNC_STAGES-1];

  // Register-port decode. An ack only counts while a request is outstanding,
  // and an EOI only counts while an interrupt is in service.
  assign cfg_wr    = I_cfgE & I_cfgWe;
  assign w1c       = cfg_wr && (I_cfgAddr == ADDR_PEND);
  assign enable_wr = cfg_wr && (I_cfgAddr == ADDR_ENABLE);
  assign eoi       = cfg_wr && (I_cfgAddr == 2'd3) && (state_reg == ST_SERVICE);
  assign ack_fire  = I_int_ack && (state_reg == ST_REQ);

  // Shift raw sources through the synchronizer.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], I_irq};
    end
  end

  // Per-source pending logic: edge sources latch, level sources follow s.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_pend
      if (EDGE_MASK[gi]) begin : g_edge
        logic s_prev_reg;
        logic pend_bit_reg;
        logic set_bit;
        logic clr_bit;

        assign set_bit = s[gi] & ~s_prev_reg;
        assign clr_bit = (ack_fire && (vec_reg == 3'(gi))) ||
                         (w1c && I_cfgWData[gi]);

        // Latch a rising edge; a simultaneous clear loses to the set.
        always_ff @(posedge I_clk or negedge I_rst_n) begin
          if (!I_rst_n) begin
            s_prev_reg   <= 1'b0;
            pend_bit_reg <= 1'b0;
          end else begin
            s_prev_reg   <= s[gi];
            pend_bit_reg <= set_bit | (pend_bit_reg & ~clr_bit);
          end
        end

        assign pend[gi] = pend_bit_reg;
      end else begin : g_level
        assign pend[gi] = s[gi];
      end
    end
  endgenerate

  assign elig = pend & enable_reg;

  // Fixed priority: lowest set index of elig wins.
  always_comb begin
    winner = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (elig[i]) begin
        winner = 3'(i);
      end
    end
  end

  // ENABLE register; a write lands at the strobe edge, so the IDLE decision
  // on that same edge still sees the previous mask.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      enable_reg <= 8'h00;
    end else if (enable_wr) begin
      enable_reg <= I_cfgWData;
    end
  end

  // Request/service sequencer with registered request outputs.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_reg      <= ST_IDLE;
      vec_reg        <= 3'd0;
      inserv_reg     <= 8'h00;
      int_req_reg    <= 1'b0;
      int_vector_reg <= 3'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (|elig) begin
            vec_reg        <= winner;
            int_vector_reg <= winner;
            int_req_reg    <= 1'b1;
            state_reg      <= ST_REQ;
          end
        end
        ST_REQ: begin
          // The vector is committed; only the ack moves us on.
          if (ack_fire) begin
            inserv_reg  <= 8'b1 << vec_reg;
            int_req_reg <= 1'b0;
            state_reg   <= ST_SERVICE;
          end
        end
        ST_SERVICE: begin
          if (eoi) begin
            inserv_reg <= 8'h00;
            state_reg  <= ST_IDLE;
          end
        end
        default: begin
          int_req_reg <= 1'b0;
          state_reg   <= ST_IDLE;
        end
      endcase
    end
  end

  // Read mux for the register port.
  always_comb begin
    rdata_next = 8'h00;
    case (I_cfgAddr)
      ADDR_PEND:   rdata_next = pend;
      ADDR_ENABLE: rdata_next = enable_reg;
      ADDR_INSERV: rdata_next = inserv_reg;
      default:     rdata_next = {3'b000, state_reg == ST_REQ,
                                 state_reg == ST_SERVICE, vec_reg};
    endcase
  end

  // Registered read data; held when no read strobe is present.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      rdata_reg <= 8'h00;
    end else if (I_cfgE && !I_cfgWe) begin
      rdata_reg <= rdata_next;
    end
  end

  assign O_int_req    = int_req_reg;
  assign O_int_vector = int_vector_reg;
  assign O_cfgRData   = rdata_reg;

endmodule

// File: tb/tb_ceespu_intc.sv
// Testbench for ceespu_intc: one all-edge instance and one instance with
// source 0 level-triggered, sharing a register/ack bus steered by sel.

module tb_ceespu_intc;

  logic       clk;
  logic       rst_n;
  logic [7:0] irq_e;
  logic [7:0] irq_l;
  logic       ack;
  logic       cfg_e;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic       sel;

  logic       req_e, req_l;
  logic [2:0] vec_e, vec_l;
  logic [7:0] rd_e, rd_l;

  logic       cur_req;
  logic [2:0] cur_vec;
  logic [7:0] cur_rd;
  logic [7:0] rd;

  int tests;
  int fails;

  ceespu_intc #(.EDGE_MASK(8'hFF), .SYNC_STAGES(2)) dut_e (
    .I_clk        (clk),
    .I_rst_n      (rst_n),
    .I_irq        (irq_e),
    .O_int_req    (req_e),
    .O_int_vector (vec_e),
    .I_int_ack    (ack & ~sel),
    .I_cfgE       (cfg_e & ~sel),
    .I_cfgWe      (cfg_we),
    .I_cfgAddr    (cfg_addr),
    .I_cfgWData   (cfg_wdata),
    .O_cfgRData   (rd_e)
  );

  ceespu_intc #(.EDGE_MASK(8'hFE), .SYNC_STAGES(2)) dut_l (
    .I_clk        (clk),
    .I_rst_n      (rst_n),
    .I_irq        (irq_l),
    .O_int_req    (req_l),
    .O_int_vector (vec_l),
    .I_int_ack    (ack & sel),
    .I_cfgE       (cfg_e & sel),
    .I_cfgWe      (cfg_we),
    .I_cfgAddr    (cfg_addr),
    .I_cfgWData   (cfg_wdata),
    .O_cfgRData   (rd_l)
  );

  assign cur_req = sel ? req_l : req_e;
  assign cur_vec = sel ? vec_l : vec_e;
  assign cur_rd  = sel ? rd_l  : rd_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: %h", name, act);
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    cfg_e = 1'b1; cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick(1);
    cfg_e = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic cfg_read(input logic [1:0] a, output logic [7:0] d);
    cfg_e = 1'b1; cfg_we = 1'b0; cfg_addr = a;
    tick(1);
    cfg_e = 1'b0;
    d = cur_rd;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  typedef enum int {OP_WR, OP_RD, OP_IRQ, OP_ACK, OP_WAIT} op_t;
  typedef struct {
    op_t        op;
    logic [1:0] addr;
    logic [7:0] data;
    int         cycles;
    logic       exp_req;
    logic [2:0] exp_vec;
    logic [7:0] exp_rd;
  } step_t;

  step_t steps [20];

  // Bounded run time.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0; irq_e = 8'hFF; irq_l = 8'h00; ack = 1'b0;
    cfg_e = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'h00; sel = 1'b0;

    // Priority / commitment scenario on the edge instance (ENABLE=FF).
    steps[0]  = '{OP_WR,   2'd1, 8'hFF, 0, 1'b0, 3'd0, 8'h00};
    steps[1]  = '{OP_IRQ,  2'd0, 8'h24, 4, 1'b1, 3'd2, 8'h00};
    steps[2]  = '{OP_ACK,  2'd0, 8'h00, 0, 1'b0, 3'd0, 8'h00};
    steps[3]  = '{OP_RD,   2'd2, 8'h00, 0, 1'b0, 3'd0, 8'h04};
    steps[4]  = '{OP_RD,   2'd0, 8'h00, 0, 1'b0, 3'd0, 8'h20};
    steps[5]  = '{OP_WR,   2'd3, 8'h00, 0, 1'b0, 3'd0, 8'h00};
    steps[6]  = '{OP_WAIT, 2'd0, 8'h00, 1, 1'b1, 3'd5, 8'h00};
    steps[7]  = '{OP_IRQ,  2'd0, 8'h26, 5, 1'b1, 3'd5, 8'h00};
    steps[8]  = '{OP_RD,   2'd0, 8'h00, 0, 1'b1, 3'd5, 8'h22};
    steps[9]  = '{OP_RD,   2'd3, 8'h00, 0, 1'b1, 3'd5, 8'h15};
    steps[10] = '{OP_ACK,  2'd0, 8'h00, 0, 1'b0, 3'd0, 8'h00};
    steps[11] = '{OP_WR,   2'd3, 8'h00, 0, 1'b0, 3'd0, 8'h00};
    steps[12] = '{OP_WAIT, 2'd0, 8'h00, 1, 1'b1, 3'd1, 8'h00};
    steps[13] = '{OP_ACK,  2'd0, 8'h00, 0, 1'b0, 3'd0, 8'h00};
    steps[14] = '{OP_WR,   2'd3, 8'h00, 0, 1'b0, 3'd0, 8'h00};
    steps[15] = '{OP_WAIT, 2'd0, 8'h00, 2, 1'b0, 3'd0, 8'h00};
    steps[16] = '{OP_RD,   2'd0, 8'h00, 0, 1'b0, 3'd0, 8'h00};
    steps[17] = '{OP_ACK,  2'd0, 8'h00, 0, 1'b0, 3'd0, 8'h00};
    steps[18] = '{OP_RD,   2'd2, 8'h00, 0, 1'b0, 3'd0, 8'h00};
    steps[19] = '{OP_RD,   2'd3, 8'h00, 0, 1'b0, 3'd0, 8'h01};

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {7'd0, req_e}, 8'h00);
    chk("rst_vec", {5'd0, vec_e}, 8'h00);
    chk("rst_rdata", rd_e, 8'h00);

    // Edge sources with ENABLE=0: all pending, no request.
    rst_n = 1'b1;
    tick(4);
    cfg_read(2'd0, rd);
    chk("pend_all", rd, 8'hFF);
    chk("pend_all_noreq", {7'd0, cur_req}, 8'h00);
    irq_e = 8'h00;
    tick(3);
    cfg_write(2'd0, 8'hFF);
    cfg_read(2'd0, rd);
    chk("w1c_clear", rd, 8'h00);

    // Interrupt latency for a one-cycle pulse on source 0.
    cfg_write(2'd1, 8'h01);
    irq_e = 8'h01;
    tick(1);
    irq_e = 8'h00;
    chk("lat_e0", {7'd0, cur_req}, 8'h00);
    tick(1);
    chk("lat_e1", {7'd0, cur_req}, 8'h00);
    tick(1);
    chk("lat_e2", {7'd0, cur_req}, 8'h00);
    tick(1);
    chk("lat_e3_req", {7'd0, cur_req}, 8'h01);
    chk("lat_e3_vec", {5'd0, cur_vec}, 8'h00);
    pulse_ack();
    chk("ack_drop", {7'd0, cur_req}, 8'h00);
    cfg_read(2'd2, rd);
    chk("inserv0", rd, 8'h01);
    cfg_read(2'd0, rd);
    chk("pend_after_ack", rd, 8'h00);
    cfg_read(2'd3, rd);
    chk("status_service", rd, 8'h08);
    cfg_write(2'd3, 8'h00);
    cfg_read(2'd3, rd);
    chk("status_after_eoi", rd, 8'h00);

    // Table-driven priority and commitment sequence.
    for (int i = 0; i < 20; i++) begin
      rd = 8'h00;
      case (steps[i].op)
        OP_WR:   cfg_write(steps[i].addr, steps[i].data);
        OP_RD:   cfg_read(steps[i].addr, rd);
        OP_IRQ:  begin irq_e = steps[i].data; tick(steps[i].cycles); end
        OP_ACK:  pulse_ack();
        default: tick(steps[i].cycles);
      endcase
      chk($sformatf("step%0d_req", i), {7'd0, cur_req}, {7'd0, steps[i].exp_req});
      if (steps[i].exp_req)
        chk($sformatf("step%0d_vec", i), {5'd0, cur_vec}, {5'd0, steps[i].exp_vec});
      if (steps[i].op == OP_RD)
        chk($sformatf("step%0d_rd", i), rd, steps[i].exp_rd);
    end

    // Level source 0 on the second instance.
    sel = 1'b1;
    cfg_write(2'd1, 8'h01);
    irq_l = 8'h01;
    tick(4);
    chk("lvl_req", {7'd0, cur_req}, 8'h01);
    chk("lvl_vec", {5'd0, cur_vec}, 8'h00);
    pulse_ack();
    chk("lvl_ack_drop", {7'd0, cur_req}, 8'h00);
    cfg_read(2'd0, rd);
    chk("lvl_pend_held", rd, 8'h01);
    cfg_write(2'd3, 8'h00);
    tick(1);
    chk("lvl_rereq", {7'd0, cur_req}, 8'h01);
    chk("lvl_rereq_vec", {5'd0, cur_vec}, 8'h00);
    cfg_write(2'd0, 8'h01);
    cfg_read(2'd0, rd);
    chk("lvl_w1c_noeffect", rd, 8'h01);

    // Reset asserted mid-SERVICE on the edge instance.
    sel = 1'b0;
    irq_e = 8'h08;
    tick(4);
    chk("svc_req", {7'd0, cur_req}, 8'h01);
    chk("svc_vec", {5'd0, cur_vec}, 8'h03);
    pulse_ack();
    cfg_read(2'd2, rd);
    chk("svc_inserv", rd, 8'h08);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_req_e", {7'd0, req_e}, 8'h00);
    chk("arst_req_l", {7'd0, req_l}, 8'h00);
    chk("arst_rdata", rd_e, 8'h00);
    irq_e = 8'h00;
    irq_l = 8'h00;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    pulse_ack();
    chk("post_rst_ack", {7'd0, cur_req}, 8'h00);
    cfg_write(2'd3, 8'h00);
    cfg_read(2'd3, rd);
    chk("post_rst_status", rd, 8'h00);
    cfg_read(2'd1, rd);
    chk("post_rst_enable", rd, 8'h00);
    cfg_read(2'd2, rd);
    chk("post_rst_inserv", rd, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
